// File: rtl/st_width_down_conv.sv
// Avalon-ST width down-converter: each RATIO*OUT_W beat leaves as n_slices OUT_W beats, MSB slice first by default.
// Latency: a beat accepted at edge N presents its first slice in cycle N+1; one input beat is buffered.
// Backpressure: data_in_ready = !full || last slice leaving; define ST_DOWN_PKT_CHECK_EN for sop/eop framing checks.
module st_width_down_conv #(
    parameter int OUT_W     = 16,
    parameter int RATIO     = 2,
    parameter int EMPTY_W   = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RATIO*OUT_W-1:0] data_in_data,
    output logic                   data_in_ready,
    input  logic                   data_in_valid,
    input  logic [EMPTY_W-1:0]     data_in_empty,
    input  logic                   data_in_startofpacket,
    input  logic                   data_in_endofpacket,
    output logic [OUT_W-1:0]       data_out_data,
    input  logic                   data_out_ready,
    output logic                   data_out_valid,
    output logic                   data_out_empty,
    output logic                   data_out_startofpacket,
    output logic                   data_out_endofpacket,
    output logic                   pkt_err
);
    localparam int IN_W  = RATIO * OUT_W;
    localparam int IDX_W = $clog2(RATIO);
    localparam int CW    = ((EMPTY_W > IDX_W) ? EMPTY_W : IDX_W) + 1;

    typedef enum logic {ST_EMPTY, ST_SEND} state_t;

    state_t           state;
    logic [IN_W-1:0]  buf_data;
    logic             buf_sop;
    logic             buf_eop;
    logic [IDX_W-1:0] buf_last;
    logic [IDX_W-1:0] idx;
    logic             full;
    logic             out_xfer;
    logic             last_slice;
    logic             in_xfer;
    logic             load;
    logic [CW-1:0]    empty_c;
    logic [IDX_W-1:0] last_in;

    assign full          = (state == ST_SEND);
    assign out_xfer      = full && data_out_ready;
    assign last_slice    = (idx == buf_last);
    assign data_in_ready = !full || (out_xfer && last_slice);
    assign in_xfer       = data_in_valid && data_in_ready;

    // Store the index of the final slice rather than a count, so it fits in IDX_W.
    always_comb begin
        empty_c = CW'(data_in_empty);
        if (empty_c > CW'(RATIO - 1))
            empty_c = CW'(RATIO - 1);
        last_in = data_in_endofpacket ? IDX_W'(CW'(RATIO - 1) - empty_c) : IDX_W'(RATIO - 1);
    end

`ifdef ST_DOWN_PKT_CHECK_EN
    logic in_pkt;
    logic err_q;

    // Beats arriving outside a packet are consumed but never loaded.
    assign load    = in_xfer && (data_in_startofpacket || in_pkt);
    assign pkt_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt <= 1'b0;
            err_q  <= 1'b0;
        end else if (in_xfer) begin
            if (data_in_startofpacket) begin
                in_pkt <= !data_in_endofpacket;
                if (in_pkt)
                    err_q <= 1'b1;
            end else if (in_pkt) begin
                in_pkt <= !data_in_endofpacket;
            end
        end
    end
`else
    assign load    = in_xfer;
    assign pkt_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            buf_data <= '0;
            buf_sop  <= 1'b0;
            buf_eop  <= 1'b0;
            buf_last <= '0;
            idx      <= '0;
        end else if (load) begin
            buf_data <= data_in_data;
            buf_sop  <= data_in_startofpacket;
            buf_eop  <= data_in_endofpacket;
            buf_last <= last_in;
            idx      <= '0;
            state    <= ST_SEND;
        end else if (out_xfer) begin
            if (last_slice) begin
                idx   <= '0;
                state <= ST_EMPTY;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        data_out_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (IDX_W'(k) == idx)
                data_out_data = MSB_FIRST ? buf_data[IN_W-1-k*OUT_W -: OUT_W]
                                          : buf_data[k*OUT_W +: OUT_W];
        end
    end

    assign data_out_valid         = full;
    assign data_out_empty         = 1'b0;
    assign data_out_startofpacket = buf_sop && (idx == '0);
    assign data_out_endofpacket   = buf_eop && last_slice;
endmodule

// File: tb/tb_st_width_down_conv.sv
// Bench for st_width_down_conv: a 2:1 (32->16) and a 4:1 (32->8) instance against a slice-queue reference model.
module tb_st_width_down_conv;
`ifdef ST_DOWN_PKT_CHECK_EN
    localparam bit PKT_CHK = 1'b1;
`else
    localparam bit PKT_CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] a_in_data, b_in_data;
    logic        a_in_ready, b_in_ready, a_in_valid, b_in_valid;
    logic [0:0]  a_in_empty;
    logic [1:0]  b_in_empty;
    logic        a_in_sop, a_in_eop, b_in_sop, b_in_eop;
    logic [15:0] a_out_data;
    logic [7:0]  b_out_data;
    logic        a_out_ready, a_out_valid, a_out_empty, a_out_sop, a_out_eop, a_pkt_err;
    logic        b_out_ready, b_out_valid, b_out_empty, b_out_sop, b_out_eop, b_pkt_err;
    bit          b_rand;

    typedef struct {logic [15:0] d; logic sop; logic eop;} slice_t;
    slice_t exp_q[2][$];
    slice_t prev[2];
    bit     prev_stall[2];
    bit     in_pkt_m[2];
    int     n_out[2];
    logic [15:0] last_d[2];
    int     n_assert, n_fail;

    st_width_down_conv #(.OUT_W(16), .RATIO(2), .EMPTY_W(1), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .data_in_data(a_in_data), .data_in_ready(a_in_ready), .data_in_valid(a_in_valid),
        .data_in_empty(a_in_empty), .data_in_startofpacket(a_in_sop), .data_in_endofpacket(a_in_eop),
        .data_out_data(a_out_data), .data_out_ready(a_out_ready), .data_out_valid(a_out_valid),
        .data_out_empty(a_out_empty), .data_out_startofpacket(a_out_sop), .data_out_endofpacket(a_out_eop),
        .pkt_err(a_pkt_err)
    );

    st_width_down_conv #(.OUT_W(8), .RATIO(4), .EMPTY_W(2), .MSB_FIRST(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .data_in_data(b_in_data), .data_in_ready(b_in_ready), .data_in_valid(b_in_valid),
        .data_in_empty(b_in_empty), .data_in_startofpacket(b_in_sop), .data_in_endofpacket(b_in_eop),
        .data_out_data(b_out_data), .data_out_ready(b_out_ready), .data_out_valid(b_out_valid),
        .data_out_empty(b_out_empty), .data_out_startofpacket(b_out_sop), .data_out_endofpacket(b_out_eop),
        .pkt_err(b_pkt_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every accepted beat expands into its slice list, MSB slice first.
    task automatic observe(input int u, input logic iv, input logic ir, input logic [31:0] id,
                           input int ie, input logic isop, input logic ieop,
                           input logic ov, input logic ordy, input logic [15:0] od,
                           input logic osop, input logic oeop, input logic oempty);
        int ratio, ow, n;
        slice_t s, e;
        ratio = (u == 0) ? 2 : 4;
        ow    = 32 / ratio;
        if (iv && ir && !(PKT_CHK && !isop && !in_pkt_m[u])) begin
            in_pkt_m[u] = !ieop;
            n = ieop ? ratio - ((ie > ratio - 1) ? ratio - 1 : ie) : ratio;
            for (int k = 0; k < n; k++) begin
                s.d   = 16'((id >> ((ratio - 1 - k) * ow)) & ((32'd1 << ow) - 1));
                s.sop = isop && (k == 0);
                s.eop = ieop && (k == n - 1);
                exp_q[u].push_back(s);
            end
        end
        if (prev_stall[u]) begin
            check_val("stall_valid", ov, 1);
            check_val("stall_data", od, prev[u].d);
            check_val("stall_sop", osop, prev[u].sop);
            check_val("stall_eop", oeop, prev[u].eop);
        end
        if (ov && ordy) begin
            n_out[u]++;
            last_d[u] = od;
            check_val("out_empty", oempty, 0);
            if (exp_q[u].size() == 0) begin
                check_val("spurious_out", ov, 0);
            end else begin
                e = exp_q[u].pop_front();
                check_val(u == 0 ? "a_data" : "b_data", od, e.d);
                check_val(u == 0 ? "a_sop" : "b_sop", osop, e.sop);
                check_val(u == 0 ? "a_eop" : "b_eop", oeop, e.eop);
            end
        end
        prev_stall[u] = ov && !ordy;
        prev[u].d     = od;
        prev[u].sop   = osop;
        prev[u].eop   = oeop;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            observe(0, a_in_valid, a_in_ready, a_in_data, int'(a_in_empty), a_in_sop, a_in_eop,
                    a_out_valid, a_out_ready, a_out_data, a_out_sop, a_out_eop, a_out_empty);
            observe(1, b_in_valid, b_in_ready, b_in_data, int'(b_in_empty), b_in_sop, b_in_eop,
                    b_out_valid, b_out_ready, {8'h00, b_out_data}, b_out_sop, b_out_eop, b_out_empty);
        end else begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (b_rand) b_out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called and returns one time unit after a rising edge.
    task automatic send_b(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] e);
        int  guard;
        bit  acc;
        guard = 0;
        acc   = 1'b0;
        b_in_data = d; b_in_sop = sop; b_in_eop = eop; b_in_empty = e; b_in_valid = 1'b1;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = b_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        b_in_valid = 1'b0;
        check_val("send_accept", acc, 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_val("drain_a", exp_q[0].size(), 0);
        check_val("drain_b", exp_q[1].size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int  n0, j, beats, len;
        bit  acc;
        n_assert = 0; n_fail = 0; b_rand = 1'b0;
        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_in_empty = '0; a_in_sop = 1'b0; a_in_eop = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_in_empty = '0; b_in_sop = 1'b0; b_in_eop = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        #3;
        check_val("rst_valid_a", a_out_valid, 0);
        check_val("rst_valid_b", b_out_valid, 0);
        check_val("rst_data_b", b_out_data, 0);
        check_val("rst_sop_b", b_out_sop, 0);
        check_val("rst_eop_b", b_out_eop, 0);
        check_val("rst_pkt_err", b_pkt_err, 0);
        #9 rst_n = 1'b1;
        idle(2);

        // Single-beat packet through the 2:1 instance, checked cycle by cycle.
        a_in_data = 32'hAABBCCDD; a_in_sop = 1'b1; a_in_eop = 1'b1; a_in_empty = '0; a_in_valid = 1'b1;
        @(negedge clk);
        check_val("t1_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        @(negedge clk);
        check_val("t1_s0_valid", a_out_valid, 1);
        check_val("t1_s0_data", a_out_data, 16'hAABB);
        check_val("t1_s0_sop", a_out_sop, 1);
        check_val("t1_s0_eop", a_out_eop, 0);
        @(negedge clk);
        check_val("t1_s1_data", a_out_data, 16'hCCDD);
        check_val("t1_s1_sop", a_out_sop, 0);
        check_val("t1_s1_eop", a_out_eop, 1);
        @(negedge clk);
        check_val("t1_idle_valid", a_out_valid, 0);
        @(posedge clk);
        #1;

        // Continuous input at full output rate: ready every second cycle, no output bubble.
        j = 0;
        a_in_data = $urandom; a_in_sop = 1'b1; a_in_eop = 1'b0; a_in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_val("tput_rdy", a_in_ready, (i % 2 == 0) ? 1 : 0);
            if (i > 0) check_val("tput_vld", a_out_valid, 1);
            acc = a_in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                j++;
                a_in_data = $urandom; a_in_sop = 1'b0; a_in_eop = (j == 7); a_in_valid = (j < 8);
            end
        end
        a_in_valid = 1'b0;
        drain();

        // 3-beat packet, last beat empty=2, on the 4:1 instance.
        n0 = n_out[1];
        send_b(32'h01020304, 1'b1, 1'b0, 2'd0);
        send_b(32'h05060708, 1'b0, 1'b0, 2'd0);
        send_b(32'h5A6B7C8D, 1'b0, 1'b1, 2'd2);
        drain();
        check_val("t2_count", n_out[1] - n0, 10);
        check_val("t2_last", last_d[1], 16'h006B);

        // Framing: stray beat, then sop,sop.
        n0 = n_out[1];
        send_b(32'hDEADBEEF, 1'b0, 1'b0, 2'd0);
        drain();
        check_val("t6_stray_out", n_out[1] - n0, PKT_CHK ? 0 : 4);
        check_val("t6_err_before", b_pkt_err, 0);
        send_b(32'h11111111, 1'b1, 1'b0, 2'd0);
        send_b(32'h22222222, 1'b1, 1'b1, 2'd1);
        drain();
        check_val("t6_err_set", b_pkt_err, PKT_CHK);

        // Long random run with random output backpressure and input gaps.
        b_rand = 1'b1;
        beats = 0;
        while (beats < 1000) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                idle($urandom_range(0, 2));
                send_b($urandom, k == 0, k == len - 1, 2'($urandom_range(0, 3)));
                beats++;
            end
        end
        drain();
        b_rand = 1'b0;
        b_out_ready = 1'b1;
        idle(1);
        check_val("t6_err_sticky", b_pkt_err, PKT_CHK);

        // Reset in the middle of a beat, after slice 0 has left.
        send_b(32'hCAFEF00D, 1'b1, 1'b0, 2'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("t5_valid_b", b_out_valid, 0);
        check_val("t5_valid_a", a_out_valid, 0);
        check_val("t5_sop_b", b_out_sop, 0);
        check_val("t5_pkt_err", b_pkt_err, 0);
        exp_q[0].delete();
        exp_q[1].delete();
        in_pkt_m[0] = 1'b0;
        in_pkt_m[1] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n0 = n_out[1];
        send_b(32'h0A0B0C0D, 1'b1, 1'b1, 2'd1);
        @(negedge clk);
        check_val("t5_new_valid", b_out_valid, 1);
        check_val("t5_new_sop", b_out_sop, 1);
        check_val("t5_new_data", b_out_data, 8'h0A);
        @(posedge clk);
        #1;
        drain();
        check_val("t5_new_count", n_out[1] - n0, 3);
        check_val("t5_last", last_d[1], 16'h000C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
